// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS front end.
//   NOP_INSTR     - encoding used for an IF/ID bubble
//   PC_INCREMENT  - byte stride between sequential fetches
//   fetch_state_e - fetch FSM state (RUN / FAULT)
package mips_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam int          PC_INCREMENT = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline flop bank.
//   clk, reset   - clock and synchronous active-high reset
//   load         - capture instr_in / pcplus4_in as a valid instruction
//   bubble       - insert a bubble (overrides load)
//   instr_in     - instruction fetched this cycle
//   pcplus4_in   - PC+4 of that instruction
//   instr, pcplus4, valid - registered IF/ID contents
// With neither load nor bubble the contents hold (stall).
module if_id_register
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  bubble,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic [DATA_WIDTH-1:0] pcplus4_in,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pcplus4,
    output logic                  valid
);

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            instr   <= DATA_WIDTH'(NOP_INSTR);
            pcplus4 <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            instr   <= instr_in;
            pcplus4 <= pcplus4_in;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: MIPS fetch stage.
//   clk, reset        - clock and synchronous active-high reset
//   Stall             - hold PC and IF/ID
//   Redirect          - taken branch/jump; overrides Stall
//   RedirectTarget    - new PC when Redirect
//   Instruction       - combinational program-memory data at PCAddress
//   PCAddress         - current PC (byte address)
//   IFID_Instruction  - registered instruction for decode
//   IFID_PCPlus4      - registered PC+4 of that instruction
//   IFID_Valid        - IF/ID holds a real instruction
//   Fault             - sticky fetch fault (misaligned / out of range)
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter int                   MEMORY_DEPTH = 32,
    parameter int                   DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Redirect,
    input  logic [DATA_WIDTH-1:0] RedirectTarget,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] PCAddress,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid,
    output logic                  Fault
);

    fetch_state_e          state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] next_pc;
    logic                  advance;
    logic                  bad_pc;
    logic                  ifid_load;
    logic                  ifid_bubble;

    // PC+4 wraps naturally at DATA_WIDTH bits.
    assign pc_plus4 = pc + DATA_WIDTH'(PC_INCREMENT);
    assign next_pc  = Redirect ? RedirectTarget : pc_plus4;
    assign advance  = Redirect || !Stall;

    // Word index is compared at full width so a wrapped or huge address
    // never aliases onto a legal word.
    assign bad_pc = (next_pc[1:0] != 2'b00) ||
                    ((next_pc >> 2) >= DATA_WIDTH'(MEMORY_DEPTH));

    // Redirect squashes the wrong-path fetch; a faulting advance also
    // leaves a bubble. Once faulted, IF/ID is pinned to a bubble.
    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b1;
        if (state == RUN) begin
            ifid_load   = !Stall;
            ifid_bubble = Redirect || (advance && bad_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= RUN;
            Fault <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (advance) begin
                        if (bad_pc) begin
                            state <= FAULT;
                            Fault <= 1'b1;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                FAULT: begin
                    Fault <= 1'b1;
                end
                default: begin
                    state <= FAULT;
                    Fault <= 1'b1;
                end
            endcase
        end
    end

    assign PCAddress = pc;

    if_id_register #(.DATA_WIDTH(DATA_WIDTH)) u_ifid (
        .clk        (clk),
        .reset      (reset),
        .load       (ifid_load),
        .bubble     (ifid_bubble),
        .instr_in   (Instruction),
        .pcplus4_in (pc_plus4),
        .instr      (IFID_Instruction),
        .pcplus4    (IFID_PCPlus4),
        .valid      (IFID_Valid)
    );

endmodule
